operand_read_stage: RTL and testbench

OPERAND_READ_STAGE -- requirements
Module: operand_read_stage

---
 rtl/operand_read_stage_pkg.sv | 25 ++
 rtl/operand_read_stage_compare.sv | 29 ++
 rtl/operand_read_stage.sv | 158 +++++++++++++++
 tb/tb_operand_read_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_read_stage_pkg.sv
// Shared constants for the operand read stage.
//   - compare function encodings (in_cmp_fn_i)
//   - jump option bit positions (in_jmp_opt_i)
//   - helper that combines compare result with jump options
package operand_read_stage_pkg;

    localparam int REG_IDX_W = 5;

    // Compare function encodings; 3'b010 / 3'b011 are unused and yield 0.
    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b100;
    localparam logic [2:0] CMP_GE  = 3'b101;
    localparam logic [2:0] CMP_LTU = 3'b110;
    localparam logic [2:0] CMP_GEU = 3'b111;

    // Jump option bits: {conditional, unconditional}.
    localparam int JMP_COND_BIT   = 1;
    localparam int JMP_UNCOND_BIT = 0;

    function automatic logic jump_taken(input logic cmp, input logic [1:0] opt);
        return (cmp && opt[JMP_COND_BIT]) || opt[JMP_UNCOND_BIT];
    endfunction

endpackage

// File: rtl/operand_read_stage_compare.sv
// Branch comparator on resolved operands.
//   i_a, i_b : operands (XLEN)
//   i_fn     : compare function
//   o_res    : compare result
module compare
    import operand_read_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [2:0]      i_fn,
    output logic            o_res
);

    always_comb begin
        o_res = 1'b0;
        case (i_fn)
            CMP_EQ:  o_res = (i_a == i_b);
            CMP_NE:  o_res = (i_a != i_b);
            CMP_LT:  o_res = ($signed(i_a) <  $signed(i_b));
            CMP_GE:  o_res = ($signed(i_a) >= $signed(i_b));
            CMP_LTU: o_res = (i_a <  i_b);
            CMP_GEU: o_res = (i_a >= i_b);
            default: o_res = 1'b0;
        endcase
    end

endmodule

// File: rtl/operand_read_stage.sv
// Operand read stage: single-entry holding register between decode and
// execute. Resolves source operands from forwarding producers or the
// register file, stalls on pending producers, and computes branch outcome.
//   clk_i/rst_ni            : clock, async active-low reset
//   in_*                    : upstream instruction + valid/ready handshake
//   rs1_o/rs2_o, rs*_value_i: register-file read port (same-cycle data)
//   fwd_*                   : NUM_FWD forwarding producers (lowest index wins)
//   flush_i                 : drop the held instruction
//   out_*                   : downstream instruction + valid/ready handshake
module operand_read_stage
    import operand_read_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int CTRL_W  = 24
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [XLEN-1:0]           in_pc_i,
    input  logic [XLEN-1:0]           in_imm_i,
    input  logic [4:0]                in_rs1_i,
    input  logic [4:0]                in_rs2_i,
    input  logic [4:0]                in_rd_i,
    input  logic [2:0]                in_cmp_fn_i,
    input  logic [1:0]                in_jmp_opt_i,
    input  logic                      in_src1_is_pc_i,
    input  logic                      in_src2_is_imm_i,
    input  logic [CTRL_W-1:0]         in_ctrl_i,
    output logic [4:0]                rs1_o,
    output logic [4:0]                rs2_o,
    input  logic [XLEN-1:0]           rs1_value_i,
    input  logic [XLEN-1:0]           rs2_value_i,
    input  logic [NUM_FWD-1:0]        fwd_valid_i,
    input  logic [NUM_FWD-1:0]        fwd_pending_i,
    input  logic [NUM_FWD*5-1:0]      fwd_rd_i,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
    input  logic                      flush_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [XLEN-1:0]           out_pc_o,
    output logic [XLEN-1:0]           out_src1_o,
    output logic [XLEN-1:0]           out_src2_o,
    output logic [XLEN-1:0]           out_store_o,
    output logic [4:0]                out_rd_o,
    output logic [CTRL_W-1:0]         out_ctrl_o,
    output logic                      out_jmp_o
);

    logic                 r_valid;
    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_imm;
    logic [4:0]           r_rs1;
    logic [4:0]           r_rs2;
    logic [4:0]           r_rd;
    logic [2:0]           r_cmp_fn;
    logic [1:0]           r_jmp_opt;
    logic                 r_src1_is_pc;
    logic                 r_src2_is_imm;
    logic [CTRL_W-1:0]    r_ctrl;

    logic [NUM_FWD-1:0]   w_hit1;
    logic [NUM_FWD-1:0]   w_hit2;
    logic [XLEN-1:0]      w_fwd1;
    logic [XLEN-1:0]      w_fwd2;
    logic                 w_pend1;
    logic                 w_pend2;
    logic [XLEN-1:0]      w_rs1_op;
    logic [XLEN-1:0]      w_rs2_op;
    logic                 w_hazard;
    logic                 w_cmp;
    logic                 w_accept;

    // Per-producer index match against the held source indices.
    for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd_match
        assign w_hit1[k] = fwd_valid_i[k] && (fwd_rd_i[k*5 +: 5] == r_rs1);
        assign w_hit2[k] = fwd_valid_i[k] && (fwd_rd_i[k*5 +: 5] == r_rs2);
    end

    // Walk from the highest producer down so the lowest-numbered hit wins.
    always_comb begin
        w_fwd1  = rs1_value_i;
        w_fwd2  = rs2_value_i;
        w_pend1 = 1'b0;
        w_pend2 = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (w_hit1[k]) begin
                w_fwd1  = fwd_data_i[k*XLEN +: XLEN];
                w_pend1 = fwd_pending_i[k];
            end
            if (w_hit2[k]) begin
                w_fwd2  = fwd_data_i[k*XLEN +: XLEN];
                w_pend2 = fwd_pending_i[k];
            end
        end
    end

    // x0 is hardwired zero and never waits on a producer.
    assign w_rs1_op = (r_rs1 == 5'd0) ? '0 : w_fwd1;
    assign w_rs2_op = (r_rs2 == 5'd0) ? '0 : w_fwd2;
    assign w_hazard = ((r_rs1 != 5'd0) && w_pend1) || ((r_rs2 != 5'd0) && w_pend2);

    compare #(.XLEN(XLEN)) u_compare (
        .i_a   (w_rs1_op),
        .i_b   (w_rs2_op),
        .i_fn  (r_cmp_fn),
        .o_res (w_cmp)
    );

    assign out_valid_o = r_valid && !w_hazard && !flush_i;
    // Flush blocks acceptance so the incoming instruction is not lost.
    assign in_ready_o  = !flush_i && (!r_valid || (out_valid_o && out_ready_i));
    assign w_accept    = in_valid_i && in_ready_o;

    assign rs1_o       = r_rs1;
    assign rs2_o       = r_rs2;
    assign out_pc_o    = r_pc;
    assign out_src1_o  = r_src1_is_pc  ? r_pc  : w_rs1_op;
    assign out_src2_o  = r_src2_is_imm ? r_imm : w_rs2_op;
    assign out_store_o = w_rs2_op;
    assign out_rd_o    = r_rd;
    assign out_ctrl_o  = r_ctrl;
    assign out_jmp_o   = jump_taken(w_cmp, r_jmp_opt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_cmp_fn      <= '0;
            r_jmp_opt     <= '0;
            r_src1_is_pc  <= 1'b0;
            r_src2_is_imm <= 1'b0;
            r_ctrl        <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid       <= 1'b1;
            r_pc          <= in_pc_i;
            r_imm         <= in_imm_i;
            r_rs1         <= in_rs1_i;
            r_rs2         <= in_rs2_i;
            r_rd          <= in_rd_i;
            r_cmp_fn      <= in_cmp_fn_i;
            r_jmp_opt     <= in_jmp_opt_i;
            r_src1_is_pc  <= in_src1_is_pc_i;
            r_src2_is_imm <= in_src2_is_imm_i;
            r_ctrl        <= in_ctrl_i;
        end else if (out_valid_o && out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_read_stage.sv
module tb_operand_read_stage;
    localparam int XLEN = 32, NUM_FWD = 2, CTRL_W = 24;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    in_valid, in_ready;
    logic [XLEN-1:0]         in_pc, in_imm;
    logic [4:0]              in_rs1, in_rs2, in_rd;
    logic [2:0]              in_fn;
    logic [1:0]              in_opt;
    logic                    in_s1pc, in_s2imm;
    logic [CTRL_W-1:0]       in_ctrl;
    logic [4:0]              rs1_o, rs2_o;
    logic [XLEN-1:0]         rs1_value, rs2_value;
    logic [NUM_FWD-1:0]      fwd_valid, fwd_pending;
    logic [4:0]              fwd_rd_a [NUM_FWD];
    logic [XLEN-1:0]         fwd_data_a [NUM_FWD];
    logic [NUM_FWD*5-1:0]    fwd_rd_p;
    logic [NUM_FWD*XLEN-1:0] fwd_data_p;
    logic                    flush, out_valid, out_ready, out_jmp;
    logic [XLEN-1:0]         out_pc, out_src1, out_src2, out_store;
    logic [4:0]              out_rd;
    logic [CTRL_W-1:0]       out_ctrl;

    logic [XLEN-1:0] rf [32];
    assign rs1_value = rf[rs1_o];
    assign rs2_value = rf[rs2_o];

    always_comb begin
        fwd_rd_p   = '0;
        fwd_data_p = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            fwd_rd_p[k*5 +: 5]      = fwd_rd_a[k];
            fwd_data_p[k*XLEN +: XLEN] = fwd_data_a[k];
        end
    end

    operand_read_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_pc_i(in_pc), .in_imm_i(in_imm),
        .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rd_i(in_rd),
        .in_cmp_fn_i(in_fn), .in_jmp_opt_i(in_opt),
        .in_src1_is_pc_i(in_s1pc), .in_src2_is_imm_i(in_s2imm),
        .in_ctrl_i(in_ctrl),
        .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rs1_value_i(rs1_value), .rs2_value_i(rs2_value),
        .fwd_valid_i(fwd_valid), .fwd_pending_i(fwd_pending),
        .fwd_rd_i(fwd_rd_p), .fwd_data_i(fwd_data_p),
        .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .out_src1_o(out_src1), .out_src2_o(out_src2),
        .out_store_o(out_store), .out_rd_o(out_rd), .out_ctrl_o(out_ctrl),
        .out_jmp_o(out_jmp)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [XLEN-1:0]   pc, imm;
        logic [4:0]        rs1, rs2, rd;
        logic [2:0]        fn;
        logic [1:0]        opt;
        logic              s1pc, s2imm;
        logic [CTRL_W-1:0] ctrl;
    } pl_t;

    pl_t  m_pl, m_pl_n;
    logic m_v, m_v_n;
    int   n_checks = 0, n_errs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic void resolve(input logic [4:0] idx, output logic [XLEN-1:0] val,
                                    output logic pend);
        logic found;
        found = 1'b0;
        val   = rf[idx];
        pend  = 1'b0;
        if (idx == 5'd0) begin
            val = '0;
        end else begin
            for (int k = 0; k < NUM_FWD; k++) begin
                if (!found && fwd_valid[k] && fwd_rd_a[k] == idx) begin
                    found = 1'b1;
                    val   = fwd_data_a[k];
                    pend  = fwd_pending[k];
                end
            end
        end
    endfunction

    function automatic logic branch_cmp(input logic [2:0] fn, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (fn)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // The single per-cycle compare of every output against the model,
    // followed by the model's next-state computation.
    task automatic check_model();
        logic [XLEN-1:0] o1, o2;
        logic p1, p2, ev, er, cmpv;
        resolve(m_pl.rs1, o1, p1);
        resolve(m_pl.rs2, o2, p2);
        ev   = m_v && !(p1 || p2) && !flush;
        er   = !flush && (!m_v || (ev && out_ready));
        cmpv = branch_cmp(m_pl.fn, o1, o2);
        chk("in_ready",  {63'd0, in_ready},  {63'd0, er});
        chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
        chk("rs1_o",     {59'd0, rs1_o},     {59'd0, m_pl.rs1});
        chk("rs2_o",     {59'd0, rs2_o},     {59'd0, m_pl.rs2});
        chk("out_pc",    {32'd0, out_pc},    {32'd0, m_pl.pc});
        chk("out_src1",  {32'd0, out_src1},  {32'd0, m_pl.s1pc ? m_pl.pc : o1});
        chk("out_src2",  {32'd0, out_src2},  {32'd0, m_pl.s2imm ? m_pl.imm : o2});
        chk("out_store", {32'd0, out_store}, {32'd0, o2});
        chk("out_rd",    {59'd0, out_rd},    {59'd0, m_pl.rd});
        chk("out_ctrl",  {40'd0, out_ctrl},  {40'd0, m_pl.ctrl});
        chk("out_jmp",   {63'd0, out_jmp},   {63'd0, (cmpv && m_pl.opt[1]) || m_pl.opt[0]});
        m_v_n  = m_v;
        m_pl_n = m_pl;
        if (!rst_n) begin
            m_v_n  = 1'b0;
            m_pl_n = '0;
        end else if (flush) begin
            m_v_n = 1'b0;
        end else if (in_valid && er) begin
            m_v_n  = 1'b1;
            m_pl_n = '{pc: in_pc, imm: in_imm, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                       fn: in_fn, opt: in_opt, s1pc: in_s1pc, s2imm: in_s2imm, ctrl: in_ctrl};
        end else if (ev && out_ready) begin
            m_v_n = 1'b0;
        end
    endtask

    // Called shortly after a negedge with inputs already set.
    task automatic cycle();
        if (!rst_n) begin
            m_v  = 1'b0;
            m_pl = '0;
        end
        #1;
        check_model();
        @(posedge clk);
        m_v  = m_v_n;
        m_pl = m_pl_n;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_fn = '0; in_opt = '0; in_s1pc = 0; in_s2imm = 0; in_ctrl = '0;
        fwd_valid = '0; fwd_pending = '0; flush = 0; out_ready = 1;
        for (int k = 0; k < NUM_FWD; k++) begin
            fwd_rd_a[k] = '0;
            fwd_data_a[k] = '0;
        end
    endtask

    task automatic set_instr(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [2:0] fn, input logic [1:0] opt);
        in_valid = 1; in_pc = pc; in_imm = pc + 32'h1000; in_rs1 = rs1; in_rs2 = rs2;
        in_rd = rs1 + rs2; in_fn = fn; in_opt = opt; in_s1pc = 0; in_s2imm = 0;
        in_ctrl = pc[CTRL_W-1:0] ^ 24'h5A5A5A;
    endtask

    task automatic issue_jmp(input string name, input logic [2:0] fn, input logic [1:0] opt,
                             input logic exp);
        set_instr(32'h300, 5'd1, 5'd2, fn, opt);
        cycle();
        idle();
        #1;
        chk(name, {63'd0, out_jmp}, {63'd0, exp});
        cycle();
    endtask

    function automatic logic [XLEN-1:0] rval();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        idle();
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[1] = 5; rf[2] = 7;
        m_v = 0; m_pl = '0;
        rst_n = 0;
        @(negedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
        chk("reset_src1",      {32'd0, out_src1},  64'd0);
        cycle();
        cycle();
        rst_n = 1;

        // add x3 = x1 + x2
        set_instr(32'h40, 5'd1, 5'd2, 3'd0, 2'b00);
        in_rd = 5'd3;
        cycle();
        idle();
        #1;
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_src1",  {32'd0, out_src1},  64'd5);
        chk("add_src2",  {32'd0, out_src2},  64'd7);
        chk("add_rd",    {59'd0, out_rd},    64'd3);
        cycle();

        // forward priority: lowest producer wins
        set_instr(32'h44, 5'd1, 5'd2, 3'd0, 2'b00);
        cycle();
        idle();
        fwd_valid = 2'b11; fwd_rd_a[0] = 5'd1; fwd_rd_a[1] = 5'd1;
        fwd_data_a[0] = 32'd9; fwd_data_a[1] = 32'd4;
        #1;
        chk("fwd_prio_src1", {32'd0, out_src1}, 64'd9);
        cycle();

        // x0 never forwards and never stalls
        set_instr(32'h48, 5'd0, 5'd2, 3'd0, 2'b00);
        cycle();
        idle();
        fwd_valid = 2'b01; fwd_rd_a[0] = 5'd0; fwd_data_a[0] = 32'd9; fwd_pending = 2'b01;
        #1;
        chk("x0_src1",  {32'd0, out_src1},  64'd0);
        chk("x0_valid", {63'd0, out_valid}, 64'd1);
        cycle();

        // pending producer on rs2 for 3 cycles
        set_instr(32'h60, 5'd1, 5'd2, 3'd0, 2'b00);
        cycle();
        set_instr(32'h80, 5'd0, 5'd0, 3'd0, 2'b00);
        fwd_valid = 2'b01; fwd_rd_a[0] = 5'd2; fwd_pending = 2'b01; fwd_data_a[0] = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("haz_valid", {63'd0, out_valid}, 64'd0);
            chk("haz_ready", {63'd0, in_ready},  64'd0);
            cycle();
        end
        fwd_pending = 2'b00; fwd_data_a[0] = 32'h55;
        #1;
        chk("haz_done_valid", {63'd0, out_valid}, 64'd1);
        chk("haz_done_src2",  {32'd0, out_src2},  64'h55);
        cycle();
        idle();
        cycle();

        // branch outcomes
        rf[1] = 32'hFFFF_FFFF; rf[2] = 32'hFFFF_FFFF;
        issue_jmp("beq_jmp", 3'b000, 2'b10, 1'b1);
        rf[2] = 32'd1;
        issue_jmp("blt_jmp", 3'b100, 2'b10, 1'b1);
        issue_jmp("bltu_jmp", 3'b110, 2'b10, 1'b0);
        issue_jmp("jal_jmp", 3'b110, 2'b01, 1'b1);

        // backpressure then flush
        set_instr(32'h100, 5'd1, 5'd2, 3'd0, 2'b00);
        cycle();
        set_instr(32'h200, 5'd2, 5'd1, 3'd0, 2'b00);
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_ready", {63'd0, in_ready},  64'd0);
            chk("bp_pc",    {32'd0, out_pc},    64'h100);
            cycle();
        end
        flush = 1;
        #1;
        chk("flush_ready", {63'd0, in_ready}, 64'd0);
        cycle();
        flush = 0;
        #1;
        chk("post_flush_valid", {63'd0, out_valid}, 64'd0);
        chk("post_flush_ready", {63'd0, in_ready},  64'd1);
        cycle();
        in_valid = 0; out_ready = 1;
        #1;
        chk("new_after_flush_pc", {32'd0, out_pc}, 64'h200);
        cycle();

        // async reset while holding
        set_instr(32'h400, 5'd1, 5'd2, 3'd0, 2'b00);
        cycle();
        idle();
        out_ready = 0;
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_ready", {63'd0, in_ready},  64'd1);
        chk("arst_pc",    {32'd0, out_pc},    64'd0);
        cycle();
        rst_n = 1;
        cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 4 == 0) rf[$urandom % 32] = rval();
            rf[0] = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : 32'h0;
            in_valid = ($urandom % 4) != 0;
            in_pc = $urandom; in_imm = rval();
            in_rs1 = ($urandom % 3 == 0) ? 5'($urandom) : 5'($urandom % 4);
            in_rs2 = ($urandom % 3 == 0) ? 5'($urandom) : 5'($urandom % 4);
            in_rd = 5'($urandom); in_fn = 3'($urandom); in_opt = 2'($urandom);
            in_s1pc = 1'($urandom); in_s2imm = 1'($urandom); in_ctrl = 24'($urandom);
            out_ready = ($urandom % 4) != 0;
            flush = ($urandom % 16) == 0;
            for (int k = 0; k < NUM_FWD; k++) begin
                fwd_valid[k]   = 1'($urandom);
                fwd_pending[k] = ($urandom % 4) == 0;
                fwd_rd_a[k]    = 5'($urandom % 4);
                fwd_data_a[k]  = rval();
            end
            rst_n = ($urandom % 500) != 0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
